// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scanner.
package ssd_pkg;

  typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex value (entry F listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/ssd_scanner_hex7seg.sv
// Combinational hex to active-low seven-segment decoder.
module hex7seg
  import ssd_pkg::*;
(
  input  logic [3:0] value,
  output logic [6:0] segments
);

  assign segments = HEX_SEG[value];

endmodule

// File: rtl/ssd_scanner.sv
// Four-digit seven-segment scan scheduler with per-slot blanking,
// per-digit blink and decimal point; all outputs registered.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int SLOT_CYCLES  = 10000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       digit0_en_i,
  input  logic       digit1_en_i,
  input  logic       digit2_en_i,
  input  logic       digit3_en_i,
  input  logic [3:0] digit0_i,
  input  logic [3:0] digit1_i,
  input  logic [3:0] digit2_i,
  input  logic [3:0] digit3_i,
  input  logic [3:0] blink_i,
  input  logic [3:0] dp_i,
  output logic [3:0] anode_o,
  output logic [6:0] segments_o,
  output logic       dp_o,
  output logic       frame_o
);

  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] BLANK_IDX  = CW'(BLANK_CYCLES);
  localparam logic [CW-1:0] LAST_IDX   = CW'(SLOT_CYCLES - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  scan_state_e   state_reg;
  logic [1:0]    slot_reg;
  logic [CW-1:0] cnt_reg;
  logic [FW-1:0] frame_cnt_reg;
  logic          blink_off_reg;
  logic          cap_en_reg, cap_blink_reg, cap_dp_reg;
  logic [3:0]    cap_val_reg;

  logic [3:0] en_vec;
  logic [3:0] digit_vec [4];
  logic       capture, drive, slot_end, frame_end, lit;
  logic       cap_en_next, cap_blink_next, cap_dp_next;
  logic [3:0] cap_val_next;
  logic [6:0] seg_dec;

  assign en_vec       = {digit3_en_i, digit2_en_i, digit1_en_i, digit0_en_i};
  assign digit_vec[0] = digit0_i;
  assign digit_vec[1] = digit1_i;
  assign digit_vec[2] = digit2_i;
  assign digit_vec[3] = digit3_i;

  // cnt_reg is the in-slot index of the cycle whose outputs are produced at this edge.
  always_comb begin
    capture        = (state_reg == SCAN_BLANK) && (cnt_reg == BLANK_IDX);
    drive          = capture || (state_reg == SCAN_DRIVE);
    slot_end       = (cnt_reg == LAST_IDX);
    frame_end      = slot_end && (slot_reg == 2'd3);
    cap_en_next    = capture ? en_vec[slot_reg]    : cap_en_reg;
    cap_val_next   = capture ? digit_vec[slot_reg] : cap_val_reg;
    cap_blink_next = capture ? blink_i[slot_reg]   : cap_blink_reg;
    cap_dp_next    = capture ? dp_i[slot_reg]      : cap_dp_reg;
    lit            = drive && cap_en_next && !(cap_blink_next && blink_off_reg);
  end

  hex7seg u_hex7seg (
    .value    (cap_val_next),
    .segments (seg_dec)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_reg     <= SCAN_BLANK;
      slot_reg      <= 2'd0;
      cnt_reg       <= '0;
      frame_cnt_reg <= '0;
      blink_off_reg <= 1'b0;
      cap_en_reg    <= 1'b0;
      cap_val_reg   <= 4'd0;
      cap_blink_reg <= 1'b0;
      cap_dp_reg    <= 1'b0;
      anode_o       <= AN_OFF;
      segments_o    <= SEG_OFF;
      dp_o          <= 1'b1;
      frame_o       <= 1'b0;
    end else begin
      state_reg     <= (drive && !slot_end) ? SCAN_DRIVE : SCAN_BLANK;
      cnt_reg       <= slot_end ? '0 : cnt_reg + 1'b1;
      cap_en_reg    <= cap_en_next;
      cap_val_reg   <= cap_val_next;
      cap_blink_reg <= cap_blink_next;
      cap_dp_reg    <= cap_dp_next;
      anode_o       <= lit ? ~(4'b0001 << slot_reg) : AN_OFF;
      segments_o    <= lit ? seg_dec : SEG_OFF;
      dp_o          <= lit ? ~cap_dp_next : 1'b1;
      frame_o       <= frame_end;
      if (slot_end) begin
        slot_reg <= slot_reg + 2'd1;
      end
      if (frame_end) begin
        if (frame_cnt_reg == FRAME_LAST) begin
          frame_cnt_reg <= '0;
          blink_off_reg <= ~blink_off_reg;
        end else begin
          frame_cnt_reg <= frame_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_ssd_scanner.sv
// Self-checking bench for ssd_scanner against a cycle-index reference model.
module tb_ssd_scanner;

  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SLOT;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] en_v = 4'hF;
  logic [3:0] dig [4];
  logic [3:0] blink_v = 4'h0;
  logic [3:0] dp_v = 4'h0;
  logic [3:0] anode_o;
  logic [6:0] segments_o;
  logic       dp_o, frame_o;

  ssd_scanner #(.SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK), .BLINK_FRAMES(BF)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .digit0_en_i (en_v[0]),
    .digit1_en_i (en_v[1]),
    .digit2_en_i (en_v[2]),
    .digit3_en_i (en_v[3]),
    .digit0_i    (dig[0]),
    .digit1_i    (dig[1]),
    .digit2_i    (dig[2]),
    .digit3_i    (dig[3]),
    .blink_i     (blink_v),
    .dp_i        (dp_v),
    .anode_o     (anode_o),
    .segments_o  (segments_o),
    .dp_o        (dp_o),
    .frame_o     (frame_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic       m_en, m_blink, m_dp;
  logic [3:0] m_val;
  int         lit_cnt [4];
  int         dp_low_cnt;
  logic [6:0] seen_seg0;

  typedef struct {
    logic [3:0] val;
    logic [6:0] seg;
  } dec_vec_t;
  dec_vec_t vecs [6];

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0h required=%0h", name, t, act, exp);
    end
  endtask

  // Anodes are never allowed to select more than one digit.
  always @(negedge clk_i) begin
    checks++;
    if ($countones(~anode_o) > 1) begin
      errors++;
      $display("FAIL onehot t=%0d actual=%b required=at most one low", t, anode_o);
    end
  end

  task automatic step();
    int slot, pos, boff;
    logic lit, ed;
    logic [3:0] ea;
    logic [6:0] es;
    @(posedge clk_i);
    slot = (t / SLOT) % 4;
    pos  = t % SLOT;
    boff = ((t / FRAME) / BF) % 2;
    if (pos == BLANK) begin
      m_en    = en_v[slot];
      m_val   = dig[slot];
      m_blink = blink_v[slot];
      m_dp    = dp_v[slot];
    end
    lit = (pos >= BLANK) && m_en && !(m_blink && boff == 1);
    ea = 4'hF;
    if (lit) ea[slot] = 1'b0;
    es = lit ? ref_seg(m_val) : 7'h7F;
    ed = lit ? ~m_dp : 1'b1;
    #1;
    check("anode", 32'(anode_o), 32'(ea));
    check("segments", 32'(segments_o), 32'(es));
    check("dp", 32'(dp_o), 32'(ed));
    check("frame", 32'(frame_o), 32'((t % FRAME) == FRAME - 1));
    if (anode_o != 4'hF) lit_cnt[slot]++;
    if (dp_o == 1'b0) dp_low_cnt++;
    if (slot == 0 && pos == SLOT - 1) seen_seg0 = segments_o;
    t++;
  endtask

  task automatic run_frame();
    for (int i = 0; i < 4; i++) lit_cnt[i] = 0;
    dp_low_cnt = 0;
    for (int c = 0; c < FRAME; c++) step();
  endtask

  // Called just after an active edge; asserts reset mid-cycle and releases it later.
  task automatic do_reset();
    #2 rst_i = 1'b1;
    #1;
    check("rst_anode", 32'(anode_o), 32'h0F);
    check("rst_segments", 32'(segments_o), 32'h7F);
    check("rst_dp", 32'(dp_o), 32'h1);
    check("rst_frame", 32'(frame_o), 32'h0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    t = 0;
  endtask

  initial begin
    vecs[0] = '{4'h0, 7'b1000000};
    vecs[1] = '{4'h1, 7'b1111001};
    vecs[2] = '{4'h8, 7'b0000000};
    vecs[3] = '{4'hA, 7'b0001000};
    vecs[4] = '{4'hF, 7'b0001110};
    vecs[5] = '{4'h5, 7'b0010010};
    dig[0] = 4'd1; dig[1] = 4'd2; dig[2] = 4'd3; dig[3] = 4'd4;

    // Reset state and first frame
    @(posedge clk_i); #2;
    check("reset_anode", 32'(anode_o), 32'h0F);
    check("reset_segments", 32'(segments_o), 32'h7F);
    check("reset_dp", 32'(dp_o), 32'h1);
    check("reset_frame", 32'(frame_o), 32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;
    run_frame();
    check("first_seg0", 32'(seen_seg0), 32'b1111001);
    check("first_lit1", 32'(lit_cnt[1]), 32'(SLOT - BLANK));
    $display("frame0 digits 1..4 seg0=%b lit1=%0d", seen_seg0, lit_cnt[1]);

    // Decode table
    for (int i = 0; i < 6; i++) begin
      for (int d = 0; d < 4; d++) dig[d] = vecs[i].val;
      run_frame();
      check("decode", 32'(seen_seg0), 32'(vecs[i].seg));
      $display("decode val=%h seg=%b", vecs[i].val, seen_seg0);
    end

    // Disabled requester
    en_v = 4'b1011;
    run_frame();
    check("disabled_slot2", 32'(lit_cnt[2]), 32'd0);
    check("disabled_slot0", 32'(lit_cnt[0]), 32'(SLOT - BLANK));
    check("disabled_slot3", 32'(lit_cnt[3]), 32'(SLOT - BLANK));
    $display("disabled digit2 lit=%0d %0d %0d %0d", lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
    en_v = 4'hF;

    // Mid-slot input change
    dig[0] = 4'h0;
    for (int c = 0; c < FRAME; c++) begin
      step();
      if (c == BLANK + 1) dig[0] = 4'h8;
    end
    check("midslot_held", 32'(seen_seg0), 32'b1000000);
    run_frame();
    check("midslot_next", 32'(seen_seg0), 32'b0000000);
    $display("midslot change held=%b next=%b", 7'b1000000, seen_seg0);

    // Decimal point
    dp_v = 4'b1000;
    run_frame();
    check("dp_low_count", 32'(dp_low_cnt), 32'(SLOT - BLANK));
    $display("dp slot3 low cycles=%0d", dp_low_cnt);
    dp_v = 4'h0;

    // Blink, counted from a fresh reset
    blink_v = 4'b0001;
    do_reset();
    for (int f = 0; f < 5; f++) begin
      run_frame();
      check("blink_d0", 32'(lit_cnt[0]), (f == 2 || f == 3) ? 32'd0 : 32'(SLOT - BLANK));
      check("blink_d1", 32'(lit_cnt[1]), 32'(SLOT - BLANK));
      $display("blink frame=%0d lit0=%0d lit1=%0d", f, lit_cnt[0], lit_cnt[1]);
    end

    // Async reset in slot-2 drive of a dark blink frame
    run_frame();
    for (int c = 0; c < 2 * SLOT + BLANK + 2; c++) step();
    check("pre_reset_lit", 32'(anode_o), 32'b1011);
    do_reset();
    run_frame();
    check("post_reset_blink_on", 32'(lit_cnt[0]), 32'(SLOT - BLANK));
    $display("async reset resume lit0=%0d", lit_cnt[0]);
    blink_v = 4'h0;

    // Randomized stimulus
    for (int f = 0; f < 16; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step();
        en_v    = 4'($urandom);
        blink_v = 4'($urandom);
        dp_v    = 4'($urandom);
        for (int d = 0; d < 4; d++) dig[d] = 4'($urandom);
      end
      $display("random frame=%0d lit=%0d %0d %0d %0d", f, lit_cnt[0], lit_cnt[1], lit_cnt[2], lit_cnt[3]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scanner.md
# ssd_scanner

Time-multiplexed seven-segment display scheduler. It shares the board's single cathode bus among the four digit requesters produced by the game FSM (digitN_en / digitN value pairs). Each digit gets a fixed-length time slot, preceded by a blanking interval that suppresses ghosting. It also applies per-digit blinking and per-digit decimal points, and sits between the game controller and the board pins.

## Interface
Parameters:
- SLOT_CYCLES, default 10000: clock cycles per digit slot, blank plus drive.
- BLANK_CYCLES, default 500: leading blank cycles per slot. Legal range is 1 ≤ BLANK_CYCLES < SLOT_CYCLES.
- BLINK_FRAMES, default 50: full 4-digit frames per blink half-period. Must be ≥ 1.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - clk_i, input, 1: system clock.
  - rst_i, input, 1: asynchronous, active-high reset.
- Digit requesters:
  - digit0_en_i … digit3_en_i, input, 1 each: digit N requests display.
  - digit0_i … digit3_i, input, 4 each: hex value for digit N.
- Display modifiers:
  - blink_i, input, 4: bit N makes digit N blink.
  - dp_i, input, 4: bit N lights the decimal point of digit N.
- Pin outputs:
  - anode_o, input/output direction output, 4, active-low: digit select.
  - segments_o, output, 7, active-low: segments {g,f,e,d,c,b,a}.
  - dp_o, output, 1, active-low: decimal point.
- Status:
  - frame_o, output, 1: one-cycle pulse at the end of each full 4-slot frame.

## Operation
- Two-state FSM:
  - SCAN_BLANK lasts BLANK_CYCLES cycles. anode_o = 4'hF, segments_o = 7'h7F, dp_o = 1.
  - SCAN_DRIVE lasts SLOT_CYCLES−BLANK_CYCLES cycles.
- On the SCAN_BLANK→SCAN_DRIVE transition, capture digit[slot]_en_i, digit[slot]_i, blink_i[slot] and dp_i[slot]. These values are held for the whole drive phase. Input changes mid-drive have no effect until the next slot.
- During SCAN_DRIVE:
  - anode_o[slot] = 0 iff captured_en && !(captured_blink && blink_off). All other anode bits are 1.
  - When the anode is asserted, segments_o = hex7seg(captured value) and dp_o = !captured_dp. When it is not asserted, the outputs are the blank values.
- On SCAN_DRIVE end:
  - State returns to SCAN_BLANK and slot increments, wrapping 3→0.
  - frame_o pulses for one cycle on the 3→0 wrap.
- Blink:
  - A frame counter counts frame_o pulses.
  - blink_off toggles after every BLINK_FRAMES frames, and the frame counter clears at that point.
  - blink_off starts at 0 (digits lit).
- Decode is standard hex 0–F, active-low, {g..a}. Required values:
  - 0 → 7'b1000000
  - 1 → 7'b1111001
  - 8 → 7'b0000000
  - A → 7'b0001000
  - F → 7'b0001110
- Counter widths are $clog2(SLOT_CYCLES) and $clog2(BLINK_FRAMES+1). There is no overflow path: compare against the terminal count minus 1, then clear.

## Timing
- Reset values, taking effect asynchronously on rst_i:
  - state = SCAN_BLANK; slot = 0; cycle and frame counters = 0; blink_off = 0.
  - anode_o = 4'hF, segments_o = 7'h7F, dp_o = 1, frame_o = 0.
- All outputs are registered. There is no combinational path from any input to any output.
- The first slot starts on the first rising edge after rst_i deasserts.
- Per slot:
  - anode_o[slot] can be low for exactly SLOT_CYCLES−BLANK_CYCLES consecutive cycles.
  - That window starts BLANK_CYCLES cycles after slot start.
- Frame period is exactly 4·SLOT_CYCLES cycles. frame_o is high in the last cycle of slot 3's drive phase.
- Blink half-period is exactly BLINK_FRAMES·4·SLOT_CYCLES cycles.
- At most one anode bit is ever low. This holds in every cycle, including across the reset edge.
- Reset asserted mid-drive forces blank outputs immediately. Scanning restarts at slot 0, and the blink phase returns to on.
- A requester whose enable is low in its slot produces a fully blank slot. Slot timing is unchanged: no skipping or compaction.

## Structure
- Package ssd_pkg holds:
  - typedef enum logic {SCAN_BLANK, SCAN_DRIVE} scan_state_e
  - localparams SEG_OFF = 7'h7F and AN_OFF = 4'hF
  - the hex-to-segment lookup constant.
- Sub-module hex7seg: purely combinational, input 4-bit value, output 7-bit active-low segments. Instantiate it once, on the captured value.

## Test plan
Bench parameters: SLOT_CYCLES=8, BLANK_CYCLES=2, BLINK_FRAMES=2.
- **Reset and first frame:** rst_i high then low; all enables = 1; digits 1,2,3,4.
  - Outputs are anode 4'hF and segments 7'h7F for 2 cycles.
  - Then anode 4'b1110 with segments 7'b1111001 for 6 cycles.
  - Then slot 1 repeats the same pattern with anode 4'b1101.
  - frame_o pulses at cycle 31.
- **Disabled requester:** digit2_en_i = 0.
  - Slot 2 shows anode 4'hF for all 8 cycles.
  - Slots 0, 1 and 3 are unaffected.
- **Mid-slot input change:** change digit0_i from 0 to 8 during slot-0 drive.
  - segments_o stays 7'b1000000 until the slot ends.
  - The next frame shows 7'b0000000.
- **Blink:** blink_i = 4'b0001.
  - Digit 0 is lit in frames 0–1, dark in frames 2–3, and lit again in frame 4.
  - Digits 1–3 are lit throughout.
- **Decimal point:** dp_i = 4'b1000, all enables = 1.
  - dp_o = 0 only during slot-3 drive cycles.
- **Async reset mid-drive:** assert rst_i partway through slot-2 drive.
  - anode_o = 4'hF before the next clock edge.
  - After release, scanning resumes at slot 0 with the blink phase on.
  - The one-hot-low anode assertion is checked in every cycle.
